spm_seq_ctrl: RTL
=================

Name: spm_seq_ctrl

Overview:
- Sequencer for the signed N×N serial-parallel multiplier (SPM) built from the bit-serial carry-save adder chain.
- Latches both operands on a start handshake and holds the multiplicand on the parallel bus.
- Streams the multiplier LSB-first with sign extension for 2N bits, then collects the 2N serial product bits into a parallel register.
- Presents the product with a valid/ready handshake; sits between the host register interface and the SPM datapath.

Parameters:
- N, 8, operand width in bits (signed two's complement).
- LAT, 1, cycles from the first serial multiplier bit on y_ser_o to the first product bit on prod_bit_i.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted only when ready_o=1.
- ready_o  out  1  controller idle and able to accept start_i.
- mcand_i  in  N  multiplicand, signed.
- mplier_i  in  N  multiplier, signed.
- x_par_o  out  N  multiplicand held for the datapath.
- y_ser_o  out  1  serial multiplier bit to the datapath.
- dp_clr_o  out  1  synchronous clear pulse to the datapath sum/carry flops.
- dp_en_o  out  1  datapath advance enable.
- prod_bit_i  in  1  serial product bit from the datapath.
- prod_o  out  2N  signed product.
- valid_o  out  1  prod_o valid.
- res_ready_i  in  1  consumer accepts prod_o.

Behaviour:
- Reset, asynchronous, all outputs and state:
  - state=IDLE, ready_o=1.
  - x_par_o=0, y_ser_o=0, dp_clr_o=0, dp_en_o=0, prod_o=0, valid_o=0.
  - Bit counter=0, operand registers=0.
- Reset asserted mid-operation aborts the transfer; no partial result is ever flagged valid.
- Bit counter width is clog2(2N+LAT+1).
- IDLE:
  - ready_o=1.
  - On start_i=1, latch mcand_i into x_par_o and mplier_i into the shift register; go to CLEAR.
- CLEAR: one cycle with dp_clr_o=1, dp_en_o=0; go to RUN; counter=0.
- RUN lasts exactly 2N+LAT cycles with dp_en_o=1.
  - y_ser_o = mplier[cnt] for cnt<N; for cnt≥N it is mplier[N-1] (sign extension).
  - y_ser_o is don't-care for the final LAT cycles and is driven as the sign bit.
  - For cnt in [LAT, 2N+LAT-1], capture prod_bit_i: prod shift register shifts right with the new bit entering at the MSB. After 2N captures, the first captured bit sits at bit 0.
  - At cnt=2N+LAT-1, go to DONE.
- DONE:
  - valid_o=1, dp_en_o=0; prod_o stable and unchanged until the handshake.
  - On res_ready_i=1, clear valid_o and return to IDLE; ready_o is 1 the following cycle.
- start_i while ready_o=0 is ignored, not queued. Operand inputs are sampled only on the accept cycle.
- A start_i held high across the DONE→IDLE transition launches a new operation in the first IDLE cycle.
- Total latency from accept to valid_o=1 is 1 (CLEAR) + 2N+LAT cycles, i.e. 18 cycles for N=8, LAT=1.
- Throughput: one product per 2N+LAT+3 cycles minimum with res_ready_i tied high.
- prod_o holds the last result through IDLE until the next capture begins.
- Arithmetic: the controller does no arithmetic. Correctness of prod_o = mcand×mplier (signed, 2N bits, no overflow) is a property of controller plus datapath together.

Decomposition:
- Package spm_pkg:
  - state enum {IDLE, CLEAR, RUN, DONE}.
  - default N and LAT constants.
  - counter-width constant derived from them.
- One natural sub-module, spm_prod_collector: 2N-bit right-shift capture register with enable.
- Operand latch and FSM stay in the top.

Test Plan:
- Benches use the team's SPM datapath instance or a cycle-accurate behavioural serial model with LAT=1.
- Scenarios:
  - N=8: mcand=3, mplier=-2 → prod_o=16'hFFFA, valid_o high exactly 18 cycles after the accept edge.
  - mcand=-128, mplier=-128 → 16'h4000; mcand=127, mplier=127 → 16'h3F01; mcand=-128, mplier=127 → 16'hC080.
  - mcand=0, mplier=-1 → 16'h0000. Check y_ser_o sequence is 16 ones and dp_clr_o pulses exactly once, before RUN.
  - Back-to-back with res_ready_i held low 5 cycles: prod_o and valid_o stay stable. start_i pulses during RUN/DONE are ignored. With start_i held high, the second op (5×-7 → 16'hFFDD) starts the cycle after the handshake.
  - Assert rst_i at RUN cnt=6: all outputs go to reset values immediately, valid_o never rises. A fresh op (-1×-1) then yields 16'h0001.
  - Randomized 1000 signed operand pairs against a reference model, with random res_ready_i back-pressure.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier (SPM) sequencer.
// Contents:
//   spm_state_e  - controller state encoding
//   SPM_N        - default operand width in bits
//   SPM_LAT      - default datapath latency from serial multiplier bit to product bit
//   SPM_CNT_W    - bit-counter width for the default configuration
//   cnt_width()  - bit-counter width for an arbitrary N / LAT pair
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } spm_state_e;

    localparam int unsigned SPM_N   = 8;
    localparam int unsigned SPM_LAT = 1;

    // The counter has to reach 2N+LAT-1 (the last RUN cycle).
    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned lat);
        return $clog2(2 * n + lat + 1);
    endfunction

    localparam int unsigned SPM_CNT_W = $clog2(2 * SPM_N + SPM_LAT + 1);

endpackage

// File: rtl/spm_prod_collector.sv
// Serial-to-parallel capture register for the SPM product.
// Each enabled cycle shifts right with the new bit entering at the MSB, so
// after W captures the first bit received (the product LSB) sits at bit 0.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset, clears the register
//   en_i    - capture enable
//   bit_i   - serial product bit, LSB first
//   prod_o  - collected product (holds its value while en_i is low)
module spm_prod_collector #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] prod_o
);

    logic [W-1:0] prod_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= {bit_i, prod_q[W-1:1]};
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the signed N x N serial-parallel multiplier.
// Latches both operands on a start handshake, holds the multiplicand on the
// parallel bus, streams the sign-extended multiplier LSB first for 2N+LAT
// cycles, collects the 2N serial product bits and presents the product with a
// valid/ready handshake.
// Ports:
//   clk_i, rst_i   - clock (rising edge), asynchronous active-high reset
//   start_i        - operation request, accepted only while ready_o=1
//   ready_o        - controller idle
//   mcand_i        - signed multiplicand, sampled on accept
//   mplier_i       - signed multiplier, sampled on accept
//   x_par_o        - multiplicand held for the datapath
//   y_ser_o        - serial multiplier bit to the datapath
//   dp_clr_o       - one-cycle clear of the datapath sum/carry flops
//   dp_en_o        - datapath advance enable
//   prod_bit_i     - serial product bit from the datapath
//   prod_o         - signed 2N-bit product
//   valid_o        - prod_o valid
//   res_ready_i    - consumer accepts prod_o
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned N   = SPM_N,
    parameter int unsigned LAT = SPM_LAT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output logic           ready_o,
    input  logic [N-1:0]   mcand_i,
    input  logic [N-1:0]   mplier_i,
    output logic [N-1:0]   x_par_o,
    output logic           y_ser_o,
    output logic           dp_clr_o,
    output logic           dp_en_o,
    input  logic           prod_bit_i,
    output logic [2*N-1:0] prod_o,
    output logic           valid_o,
    input  logic           res_ready_i
);

    localparam int unsigned CNT_W = cnt_width(N, LAT);
    localparam logic [CNT_W-1:0] LAT_C      = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] RUN_LAST_C = CNT_W'(2 * N + LAT - 1);

    spm_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N-1:0]     x_par_q;
    logic [N-1:0]     mplier_q;
    logic             y_ser_q;
    logic             dp_clr_q;
    logic             dp_en_q;
    logic             valid_q;
    logic             ready_q;
    logic             capture_en;

    assign cnt_d = cnt_q + 1'b1;

    // The first LAT RUN cycles only fill the datapath pipeline; product bits
    // start arriving afterwards.
    assign capture_en = (state_q == RUN) && (cnt_q >= LAT_C);

    // The multiplier register is an arithmetic right shifter: bit 0 is the
    // next serial bit and the replicated MSB provides the sign extension for
    // the upper N bits and the trailing LAT cycles. All outputs are registered
    // so they change together with the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_par_q  <= '0;
            mplier_q <= '0;
            y_ser_q  <= 1'b0;
            dp_clr_q <= 1'b0;
            dp_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        x_par_q  <= mcand_i;
                        mplier_q <= mplier_i;
                        ready_q  <= 1'b0;
                        dp_clr_q <= 1'b1;
                        state_q  <= CLEAR;
                    end
                end
                CLEAR: begin
                    dp_clr_q <= 1'b0;
                    dp_en_q  <= 1'b1;
                    cnt_q    <= '0;
                    y_ser_q  <= mplier_q[0];
                    mplier_q <= {mplier_q[N-1], mplier_q[N-1:1]};
                    state_q  <= RUN;
                end
                RUN: begin
                    if (cnt_q == RUN_LAST_C) begin
                        dp_en_q <= 1'b0;
                        y_ser_q <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q    <= cnt_d;
                        y_ser_q  <= mplier_q[0];
                        mplier_q <= {mplier_q[N-1], mplier_q[N-1:1]};
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    spm_prod_collector #(
        .W (2 * N)
    ) u_collector (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (capture_en),
        .bit_i  (prod_bit_i),
        .prod_o (prod_o)
    );

    assign ready_o  = ready_q;
    assign x_par_o  = x_par_q;
    assign y_ser_o  = y_ser_q;
    assign dp_clr_o = dp_clr_q;
    assign dp_en_o  = dp_en_q;
    assign valid_o  = valid_q;

endmodule
